dram_wb_arbiter: RTL

Two-master Wishbone arbiter that shares the single SDRAM controller port between the CPU path (master 0) and the DMA read engine (master 1).
- Grants are round-robin on tie, and a grant is held for the owner's whole `cyc` window so that SDRAM burst reads are never split.
- A per-grant watchdog aborts a stalled access.
- Sits between the user-project Wishbone decode / DMA and the SDRAM controller's `wbs_*` slave port.

---
 rtl/dram_wb_arbiter.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/dram_wb_arbiter.sv
// dram_wb_arbiter
//
// Arbitrates two Wishbone masters onto the single SDRAM controller slave port.
// Master 0 is the CPU path and master 1 is the DMA read engine.
//   - Ties are broken round-robin. The master that was not granted last wins.
//   - A grant is held for the owner's whole cyc window, so burst reads are never split.
//   - A per-grant watchdog aborts an access that stalls with no ack and no burst beat.
//     The abort returns err to the owner and drains until the owner drops cyc.
//
// Ports:
//   wb_clk_i, wb_rst_i          clock and synchronous active-high reset
//   m0_*                        CPU master: cyc/stb/we/sel/adr/dat in, ack/err/dat out
//   m1_*                        DMA master: cyc/stb/we/adr in, ack/burst/err/dat out
//   s_*                         SDRAM slave: cyc/stb/we/sel/adr/dat out, ack/burst/dat in
//   gnt_o                       one-hot current owner (bit0 = M0, bit1 = M1)

module dram_wb_arbiter #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned TIMEOUT    = 255
) (
   input  logic                  wb_clk_i,
   input  logic                  wb_rst_i,
   // master 0 (CPU)
   input  logic                  m0_cyc_i,
   input  logic                  m0_stb_i,
   input  logic                  m0_we_i,
   input  logic [3:0]            m0_sel_i,
   input  logic [ADDR_WIDTH-1:0] m0_adr_i,
   input  logic [DATA_WIDTH-1:0] m0_dat_i,
   output logic                  m0_ack_o,
   output logic                  m0_err_o,
   output logic [DATA_WIDTH-1:0] m0_dat_o,
   // master 1 (DMA, read only)
   input  logic                  m1_cyc_i,
   input  logic                  m1_stb_i,
   input  logic                  m1_we_i,
   input  logic [ADDR_WIDTH-1:0] m1_adr_i,
   output logic                  m1_ack_o,
   output logic                  m1_burst_o,
   output logic                  m1_err_o,
   output logic [DATA_WIDTH-1:0] m1_dat_o,
   // SDRAM slave port
   output logic                  s_cyc_o,
   output logic                  s_stb_o,
   output logic                  s_we_o,
   output logic [3:0]            s_sel_o,
   output logic [ADDR_WIDTH-1:0] s_adr_o,
   output logic [DATA_WIDTH-1:0] s_dat_o,
   input  logic                  s_ack_i,
   input  logic                  s_burst_i,
   input  logic [DATA_WIDTH-1:0] s_dat_i,
   // current owner
   output logic [1:0]            gnt_o
);

   localparam int unsigned CntWidth = $clog2(TIMEOUT + 1);
   localparam logic [CntWidth-1:0] TimeoutVal = CntWidth'(TIMEOUT);

   typedef enum logic [2:0] {
      StIdle,
      StOwnM0,
      StOwnM1,
      StRelease,
      StAbort,
      StDrain
   } state_e;

   state_e              state_q, state_d;
   logic                last_gnt_q, last_gnt_d;   // 0 = M0 granted last, 1 = M1
   logic                abort_m1_q, abort_m1_d;   // which master was aborted
   logic [CntWidth-1:0] wdog_q, wdog_d;

   logic own_cyc;
   logic own_stb;

   // ---------------------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_q    <= StIdle;
         last_gnt_q <= 1'b1;   // M1 counts as last, so M0 wins the first tie
         abort_m1_q <= 1'b0;
         wdog_q     <= '0;
      end else begin
         state_q    <= state_d;
         last_gnt_q <= last_gnt_d;
         abort_m1_q <= abort_m1_d;
         wdog_q     <= wdog_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Next-state, grant and watchdog
   // ---------------------------------------------------------------------------
   always_comb begin
      own_cyc = (state_q == StOwnM1) ? m1_cyc_i : m0_cyc_i;
      own_stb = (state_q == StOwnM1) ? m1_stb_i : m0_stb_i;
   end

   always_comb begin
      state_d    = state_q;
      last_gnt_d = last_gnt_q;
      abort_m1_d = abort_m1_q;
      // The counter is zero in every non-owning state, so it starts at zero on each grant.
      wdog_d     = '0;

      unique case (state_q)
         StIdle: begin
            if (m0_cyc_i && (!m1_cyc_i || last_gnt_q)) begin
               state_d    = StOwnM0;
               last_gnt_d = 1'b0;
            end else if (m1_cyc_i) begin
               state_d    = StOwnM1;
               last_gnt_d = 1'b1;
            end
         end

         StOwnM0, StOwnM1: begin
            if (!own_cyc) begin
               state_d = StRelease;
            end else if (wdog_q == TimeoutVal) begin
               state_d    = StAbort;
               abort_m1_d = (state_q == StOwnM1);
            end else if (s_ack_i || s_burst_i) begin
               wdog_d = '0;
            end else if (own_stb) begin
               wdog_d = wdog_q + CntWidth'(1);
            end else begin
               wdog_d = wdog_q;
            end
         end

         StRelease: state_d = StIdle;

         StAbort: state_d = StDrain;

         StDrain: begin
            if (!(abort_m1_q ? m1_cyc_i : m0_cyc_i)) begin
               state_d = StIdle;
            end
         end

         default: state_d = StIdle;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Datapath muxing: only the owner is connected to the slave. Every other
   // state drives zeros, so slave responses arriving then are dropped.
   // ---------------------------------------------------------------------------
   always_comb begin
      s_cyc_o    = 1'b0;
      s_stb_o    = 1'b0;
      s_we_o     = 1'b0;
      s_sel_o    = 4'h0;
      s_adr_o    = '0;
      s_dat_o    = '0;
      m0_ack_o   = 1'b0;
      m0_err_o   = 1'b0;
      m0_dat_o   = '0;
      m1_ack_o   = 1'b0;
      m1_burst_o = 1'b0;
      m1_err_o   = 1'b0;
      m1_dat_o   = '0;
      gnt_o      = 2'b00;

      unique case (state_q)
         StOwnM0: begin
            s_cyc_o  = m0_cyc_i;
            s_stb_o  = m0_stb_i;
            s_we_o   = m0_we_i;
            s_sel_o  = m0_sel_i;
            s_adr_o  = m0_adr_i;
            s_dat_o  = m0_dat_i;
            m0_ack_o = s_ack_i;
            m0_dat_o = s_dat_i;
            gnt_o    = 2'b01;
         end

         StOwnM1: begin
            // The DMA has no write data path; present full byte lanes and zero data.
            s_cyc_o    = m1_cyc_i;
            s_stb_o    = m1_stb_i;
            s_we_o     = m1_we_i;
            s_sel_o    = 4'hF;
            s_adr_o    = m1_adr_i;
            m1_ack_o   = s_ack_i;
            m1_burst_o = s_burst_i;
            m1_dat_o   = s_dat_i;
            gnt_o      = 2'b10;
         end

         StAbort: begin
            m0_err_o = ~abort_m1_q;
            m1_err_o = abort_m1_q;
         end

         default: ;
      endcase
   end

endmodule
